// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and defaults for the ucpu micro-instruction sequencer.
package cpu_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    STEP   = 3'd6
  } cpu_state_t;
  localparam int CPU_STATES = 7;
  localparam int EXEC_MAX_DEF = 8;
endpackage

// File: rtl/cpu_seq_cnt.sv
// cpu_seq_cnt: loadable up-counter that saturates at limit and flags terminal count.
module cpu_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == limit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (ld) cnt <= d;
    else if (inc && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cpu_seq_fsm.sv
// cpu_seq_fsm: FETCH/DECODE/EXEC/MEM/WB instruction sequencer with HALT; define CPU_SEQ_STEP_EN for single-step.
module cpu_seq_fsm
  import cpu_pkg::*;
#(
  parameter int EXEC_MAX = EXEC_MAX_DEF,
  parameter int MEM_WAIT_MAX = 15,
  parameter int RET_W = 16,
  localparam int CNT_W = $clog2(EXEC_MAX + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             fetch_ack,
  input  logic             is_nop,
  input  logic             is_mem,
  input  logic             is_halt,
  input  logic [CNT_W-1:0] exec_cycles,
  input  logic             mem_ready,
  input  logic             resume,
  input  logic             step_req,
  output logic [2:0]       cpu_state,
  output logic [CNT_W-1:0] current_minst,
  output logic             fetch_req,
  output logic             mem_req,
  output logic             wb_en,
  output logic             instr_done,
  output logic [RET_W-1:0] retired,
  output logic             mem_err
);
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  cpu_state_t state, nxt;
  logic [CNT_W-1:0] exec_last;
  logic [WAIT_W-1:0] unused_wait_cnt;
  logic mem_pend, exec_tc, wait_tc, entry;
  assign cpu_state = state;
  assign entry = nxt != state;
  cpu_seq_cnt #(.W(CNT_W)) u_exec_cnt (
    .clk(sys_clk), .rst_n(sys_reset_n), .ld(entry), .d('0),
    .inc(state == EXEC), .limit(exec_last), .cnt(current_minst), .tc(exec_tc)
  );
  cpu_seq_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk(sys_clk), .rst_n(sys_reset_n), .ld(entry), .d('0),
    .inc(state == MEM), .limit(WAIT_W'(MEM_WAIT_MAX - 1)), .cnt(unused_wait_cnt), .tc(wait_tc)
  );
`ifndef CPU_SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step_req;
`endif
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = fetch_ack ? DECODE : FETCH;
      DECODE: nxt = is_halt ? HALT : is_nop ? WB : EXEC;
      EXEC:   nxt = !exec_tc ? EXEC : mem_pend ? MEM : WB;
      MEM:    nxt = mem_ready ? WB : wait_tc ? HALT : MEM;
`ifdef CPU_SEQ_STEP_EN
      WB:     nxt = STEP;
      STEP:   nxt = step_req ? FETCH : STEP;
`else
      WB:     nxt = FETCH;
`endif
      HALT:   nxt = resume ? FETCH : HALT;
      default: nxt = FETCH;
    endcase
  end
  // Outputs decode the next state so they line up with the registered cpu_state.
  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) begin
      state      <= FETCH;
      exec_last  <= '0;
      mem_pend   <= 1'b0;
      fetch_req  <= 1'b0;
      mem_req    <= 1'b0;
      wb_en      <= 1'b0;
      instr_done <= 1'b0;
      retired    <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= nxt;
      fetch_req  <= nxt == FETCH;
      mem_req    <= nxt == MEM;
      instr_done <= nxt == WB;
      wb_en      <= nxt == WB && state != DECODE;
      retired    <= retired + RET_W'(nxt == WB);
      mem_err    <= state == MEM && nxt == HALT ? 1'b1 : state == HALT && nxt == FETCH ? 1'b0 : mem_err;
      if (state == DECODE) begin
        exec_last <= exec_cycles == '0 ? '0 :
                     exec_cycles > CNT_W'(EXEC_MAX) ? CNT_W'(EXEC_MAX - 1) : exec_cycles - 1'b1;
        mem_pend  <= is_mem;
      end
    end
endmodule
